// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings and BCD limits for the HH:MM:SS countdown timer
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam logic [1:0] SEL_SS   = 2'd0;
    localparam logic [1:0] SEL_MM   = 2'd1;
    localparam logic [1:0] SEL_HH   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    localparam logic [3:0] DIG_MAX     = 4'd9;
    localparam logic [3:0] TENS_MAX_MS = 4'd5;
    localparam logic [3:0] HH_TENS_MAX = 4'd2;
    localparam logic [7:0] HH_MAX      = 8'h23;

    // A start time is accepted only if every field is a legal clock value.
    function automatic logic load_ok(input logic [7:0] hh, input logic [7:0] mm,
                                     input logic [7:0] ss);
        return (hh[3:0] <= DIG_MAX) && (hh[7:4] <= DIG_MAX) && (hh <= HH_MAX) &&
               (mm[3:0] <= DIG_MAX) && (mm[7:4] <= TENS_MAX_MS) &&
               (ss[3:0] <= DIG_MAX) && (ss[7:4] <= TENS_MAX_MS);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - one BCD digit of the decrement borrow chain
module bcd_digit_dec
    import timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] next,
    output logic       borrow_out
);

    always_comb begin
        next       = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                next       = max;
                borrow_out = 1'b1;
            end else begin
                next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_cuenta_bcd.sv
// rtl/timer_cuenta_bcd.sv - BCD HH:MM:SS countdown timer; TIMER_AUTORELOAD_EN enables shadow reload
module timer_cuenta_bcd
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       start,
    input  logic       stop,
    input  logic       alarm_ack,
    input  logic [1:0] field_sel,
    output logic [7:0] out_count_dato,
    output logic [7:0] out_hh,
    output logic [7:0] out_mm,
    output logic [7:0] out_ss,
    output logic       running,
    output logic       estado_alarma,
    output logic       tick_out,
    output logic       load_err
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [7:0]    hh, mm, ss;
    logic [7:0]    hh_n, mm_n, ss_n;
    logic [6:0]    brw;
    logic          load_err_q;
    logic          alarm_pulse;
    logic          load_valid;
    logic          is_zero;
    logic          at_one;
    logic          tick;
`ifdef TIMER_AUTORELOAD_EN
    logic [23:0]   shadow;
`endif

    // Borrow enters the seconds units on every tick; it leaves the hours tens only from 00:00:00.
    assign brw[0] = 1'b1;

    bcd_digit_dec u_ss_u (.digit(ss[3:0]), .max(DIG_MAX),     .borrow_in(brw[0]), .next(ss_n[3:0]), .borrow_out(brw[1]));
    bcd_digit_dec u_ss_t (.digit(ss[7:4]), .max(TENS_MAX_MS), .borrow_in(brw[1]), .next(ss_n[7:4]), .borrow_out(brw[2]));
    bcd_digit_dec u_mm_u (.digit(mm[3:0]), .max(DIG_MAX),     .borrow_in(brw[2]), .next(mm_n[3:0]), .borrow_out(brw[3]));
    bcd_digit_dec u_mm_t (.digit(mm[7:4]), .max(TENS_MAX_MS), .borrow_in(brw[3]), .next(mm_n[7:4]), .borrow_out(brw[4]));
    bcd_digit_dec u_hh_u (.digit(hh[3:0]), .max(DIG_MAX),     .borrow_in(brw[4]), .next(hh_n[3:0]), .borrow_out(brw[5]));
    bcd_digit_dec u_hh_t (.digit(hh[7:4]), .max(HH_TENS_MAX), .borrow_in(brw[5]), .next(hh_n[7:4]), .borrow_out(brw[6]));

    assign is_zero    = brw[6];
    assign at_one     = ({hh, mm, ss} == 24'h00_00_01);
    assign load_valid = load && load_ok(load_hh, load_mm, load_ss);
    // A load or stop in the same cycle pre-empts the decrement.
    assign tick       = (state == ST_RUN) && (presc == PRESC_MAX) && !load && !stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            presc       <= '0;
            hh          <= 8'h00;
            mm          <= 8'h00;
            ss          <= 8'h00;
            load_err_q  <= 1'b0;
            alarm_pulse <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            shadow      <= 24'h00_00_00;
`endif
        end else begin
            load_err_q  <= load && !load_valid;
            alarm_pulse <= 1'b0;
            if (load) begin
                if (load_valid) begin
                    hh    <= load_hh;
                    mm    <= load_mm;
                    ss    <= load_ss;
                    state <= ST_IDLE;
                    presc <= '0;
`ifdef TIMER_AUTORELOAD_EN
                    shadow <= {load_hh, load_mm, load_ss};
`endif
                end
            end else if (stop && state == ST_RUN) begin
                state <= ST_PAUSE;
            end else if (start && ((state == ST_IDLE && !is_zero) || state == ST_PAUSE)) begin
                // Resuming from PAUSE keeps the prescaler so paused time causes no drift.
                if (state == ST_IDLE) begin
                    presc <= '0;
                end
                state <= ST_RUN;
            end else if (state == ST_ALARM && alarm_ack) begin
                state <= ST_IDLE;
            end else if (state == ST_RUN) begin
                if (tick) begin
                    presc <= '0;
`ifdef TIMER_AUTORELOAD_EN
                    if (at_one && shadow != 24'h00_00_00) begin
                        {hh, mm, ss} <= shadow;
                        alarm_pulse  <= 1'b1;
                    end else
`endif
                    begin
                        hh <= hh_n;
                        mm <= mm_n;
                        ss <= ss_n;
                        if (at_one) begin
                            state <= ST_ALARM;
                        end
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    always_comb begin
        out_count_dato = 8'h00;
        case (field_sel)
            SEL_SS:   out_count_dato = ss;
            SEL_MM:   out_count_dato = mm;
            SEL_HH:   out_count_dato = hh;
            SEL_ZERO: out_count_dato = 8'h00;
            default:  out_count_dato = 8'h00;
        endcase
    end

    assign out_hh        = hh;
    assign out_mm        = mm;
    assign out_ss        = ss;
    assign running       = (state == ST_RUN);
    assign estado_alarma = (state == ST_ALARM) || alarm_pulse;
    assign tick_out      = tick;
    assign load_err      = load_err_q;

endmodule

// File: tb/tb_timer_cuenta_bcd.sv
// tb/tb_timer_cuenta_bcd.sv - directed self-checking bench for timer_cuenta_bcd (TICK_DIV=4)
module tb_timer_cuenta_bcd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_hh = 8'h00;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [1:0] field_sel = 2'd0;
    logic [7:0] out_count_dato, out_hh, out_mm, out_ss;
    logic       running, estado_alarma, tick_out, load_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    timer_cuenta_bcd #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .load_hh(load_hh), .load_mm(load_mm),
        .load_ss(load_ss), .start(start), .stop(stop), .alarm_ack(alarm_ack),
        .field_sel(field_sel), .out_count_dato(out_count_dato), .out_hh(out_hh),
        .out_mm(out_mm), .out_ss(out_ss), .running(running), .estado_alarma(estado_alarma),
        .tick_out(tick_out), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [23:0] v);
        {load_hh, load_mm, load_ss} = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (!tick_out && n < 16) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        step();
        total_cnt++;
        if ({out_hh, out_mm, out_ss} !== 24'h000000) $display("FAIL rst_fields got %h exp 000000", {out_hh, out_mm, out_ss}); else pass_cnt++;
        total_cnt++;
        if ({running, estado_alarma, tick_out, load_err} !== 4'b0000) $display("FAIL rst_flags got %b exp 0000", {running, estado_alarma, tick_out, load_err}); else pass_cnt++;
        reset = 1'b0;
        step();
        pulse_start();
        total_cnt++;
        if (running !== 1'b0) $display("FAIL start_at_zero_after_reset got %b exp 0", running); else pass_cnt++;
    endtask

    task automatic test_countdown();
        int n;
        do_load(24'h000003);
        total_cnt++;
        if (out_ss !== 8'h03 || load_err !== 1'b0) $display("FAIL cd_load got ss=%h err=%b exp 03 0", out_ss, load_err); else pass_cnt++;
        pulse_start();
        total_cnt++;
        if (running !== 1'b1) $display("FAIL cd_running got %b exp 1", running); else pass_cnt++;
        for (int k = 2; k >= 0; k--) begin
            wait_tick(n);
            total_cnt++;
            if (n !== 3 || out_ss !== 8'(k + 1) || estado_alarma !== 1'b0) $display("FAIL cd_tick%0d got wait=%0d ss=%h al=%b exp 3 %h 0", k, n, out_ss, estado_alarma, 8'(k + 1)); else pass_cnt++;
            step();
            total_cnt++;
            if (out_ss !== 8'(k)) $display("FAIL cd_ss%0d got %h exp %h", k, out_ss, 8'(k)); else pass_cnt++;
        end
        total_cnt++;
        if ({estado_alarma, running, tick_out} !== 3'b100) $display("FAIL cd_alarm got %b exp 100", {estado_alarma, running, tick_out}); else pass_cnt++;
    endtask

    task automatic test_alarm_ack();
        pulse_start();
        total_cnt++;
        if (estado_alarma !== 1'b1 || running !== 1'b0) $display("FAIL ack_start_ignored got al=%b run=%b exp 1 0", estado_alarma, running); else pass_cnt++;
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        total_cnt++;
        if (estado_alarma !== 1'b0) $display("FAIL ack_clear got %b exp 0", estado_alarma); else pass_cnt++;
        pulse_start();
        for (int i = 0; i < 6; i++) step();
        total_cnt++;
        if (running !== 1'b0 || out_ss !== 8'h00) $display("FAIL ack_zero_start got run=%b ss=%h exp 0 00", running, out_ss); else pass_cnt++;
    endtask

    task automatic test_borrow();
        logic [23:0] vin [5] = '{24'h010000, 24'h100000, 24'h200000, 24'h230000, 24'h001000};
        logic [23:0] vexp [5] = '{24'h005959, 24'h095959, 24'h195959, 24'h225959, 24'h000959};
        logic [7:0]  sel_exp [4] = '{8'h59, 8'h59, 8'h00, 8'h00};
        int n;
        for (int i = 0; i < 5; i++) begin
            do_load(vin[i]);
            pulse_start();
            wait_tick(n);
            step();
            total_cnt++;
            if ({out_hh, out_mm, out_ss} !== vexp[i]) $display("FAIL borrow%0d got %h exp %h (wait %0d)", i, {out_hh, out_mm, out_ss}, vexp[i], n); else pass_cnt++;
            if (i == 0) begin
                for (int s = 0; s < 4; s++) begin
                    field_sel = 2'(s);
                    #1;
                    total_cnt++;
                    if (out_count_dato !== sel_exp[s]) $display("FAIL field_sel%0d got %h exp %h", s, out_count_dato, sel_exp[s]); else pass_cnt++;
                end
                field_sel = 2'd0;
            end
            pulse_stop();
        end
    endtask

    task automatic test_load_err();
        logic [23:0] bad [5] = '{24'h006100, 24'h240000, 24'h1A0000, 24'h00005A, 24'h000060};
        // Timer is paused at 00:09:59 here.
        for (int i = 0; i < 5; i++) begin
            do_load(bad[i]);
            total_cnt++;
            if (load_err !== 1'b1 || {out_hh, out_mm, out_ss} !== 24'h000959 || running !== 1'b0) $display("FAIL load_err%0d got err=%b f=%h run=%b exp 1 000959 0", i, load_err, {out_hh, out_mm, out_ss}, running); else pass_cnt++;
        end
        step();
        total_cnt++;
        if (load_err !== 1'b0) $display("FAIL load_err_pulse got %b exp 0", load_err); else pass_cnt++;
        do_load(24'h000500);
        pulse_start();
        do_load(24'h006100);
        total_cnt++;
        if (load_err !== 1'b1 || running !== 1'b1 || {out_hh, out_mm, out_ss} !== 24'h000500) $display("FAIL load_err_run got err=%b run=%b f=%h exp 1 1 000500", load_err, running, {out_hh, out_mm, out_ss}); else pass_cnt++;
    endtask

    task automatic test_pause_resume();
        int n;
        int early;
        do_load(24'h000009);
        pulse_start();
        step();
        step();
        pulse_stop();
        total_cnt++;
        if (running !== 1'b0) $display("FAIL pause_running got %b exp 0", running); else pass_cnt++;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            if (tick_out) early++;
            step();
        end
        total_cnt++;
        if (early !== 0 || out_ss !== 8'h09) $display("FAIL pause_hold got ticks=%0d ss=%h exp 0 09", early, out_ss); else pass_cnt++;
        pulse_start();
        wait_tick(n);
        total_cnt++;
        if (n !== 1) $display("FAIL resume_drift got wait=%0d exp 1", n); else pass_cnt++;
        step();
        total_cnt++;
        if (out_ss !== 8'h08) $display("FAIL resume_dec got %h exp 08", out_ss); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_load(24'h000007);
        {load_hh, load_mm, load_ss} = 24'h000005;
        load = 1'b1;
        start = 1'b1;
        step();
        load = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (running !== 1'b0 || out_ss !== 8'h05) $display("FAIL prio_load_start got run=%b ss=%h exp 0 05", running, out_ss); else pass_cnt++;
        pulse_start();
        stop = 1'b1;
        start = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (running !== 1'b0) $display("FAIL prio_stop_start got %b exp 0", running); else pass_cnt++;
    endtask

    task automatic test_reset_midcount();
        do_load(24'h000005);
        pulse_start();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_hh, out_mm, out_ss} !== 24'h000000 || {running, estado_alarma, tick_out} !== 3'b000) $display("FAIL midreset got f=%h flags=%b exp 000000 000", {out_hh, out_mm, out_ss}, {running, estado_alarma, tick_out}); else pass_cnt++;
        step();
        reset = 1'b0;
        step();
        total_cnt++;
        if ({running, estado_alarma, tick_out, load_err} !== 4'b0000) $display("FAIL midreset_after got %b exp 0000", {running, estado_alarma, tick_out, load_err}); else pass_cnt++;
    endtask

`ifdef TIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        int n;
        do_load(24'h000002);
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            wait_tick(n);
            step();
            total_cnt++;
            if (out_ss !== 8'h01 || estado_alarma !== 1'b0) $display("FAIL ar_first%0d got ss=%h al=%b exp 01 0", r, out_ss, estado_alarma); else pass_cnt++;
            wait_tick(n);
            step();
            total_cnt++;
            if (n !== 3 || out_ss !== 8'h02 || estado_alarma !== 1'b1 || running !== 1'b1) $display("FAIL ar_reload%0d got wait=%0d ss=%h al=%b run=%b exp 3 02 1 1", r, n, out_ss, estado_alarma, running); else pass_cnt++;
            step();
            total_cnt++;
            if (estado_alarma !== 1'b0) $display("FAIL ar_pulse%0d got %b exp 0", r, estado_alarma); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef TIMER_AUTORELOAD_EN
        test_autoreload();
`else
        test_countdown();
        test_alarm_ack();
`endif
        test_borrow();
        test_load_err();
        test_pause_resume();
        test_back_to_back();
        test_reset_midcount();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
